// File: rtl/line_engine_if.sv
// Pixel write bus between the line engine and the frame-buffer write path.
// No latency of its own; it only carries the signals.
// A write completes on a clk edge where px_valid and px_ready are both high.
interface line_engine_if;
    logic [31:0] px_addr;
    logic [31:0] px_data;
    logic [3:0]  px_we;
    logic        px_valid;
    logic        px_ready;

    modport master (
        output px_addr,
        output px_data,
        output px_we,
        output px_valid,
        input  px_ready
    );

    modport slave (
        input  px_addr,
        input  px_data,
        input  px_we,
        input  px_valid,
        output px_ready
    );
endinterface

// File: rtl/line_engine.sv
// Bresenham line rasterizer: CPU-loaded endpoints and color in, one frame-buffer pixel write out per handshake.
// Latency: the first pixel is valid 3 cycles after the trigger cycle; after that, one pixel per accepted cycle.
// Backpressure: while px_ready is low, the current pixel (addr/data/we) is held and nothing advances.
module line_engine #(
    parameter logic [31:0] FB_BASE = 32'h1080_0000,
    parameter int          COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        line_color,
    input  logic [COORD_W-1:0] line_point,
    input  logic               line_color_valid,
    input  logic               line_x0_valid,
    input  logic               line_y0_valid,
    input  logic               line_x1_valid,
    input  logic               line_y1_valid,
    input  logic               line_trigger,
    output logic               line_ready,
    line_engine_if.master      px
);
    localparam int CW = COORD_W;
    localparam logic [CW-1:0] ONE = 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP1 = 2'd1;
    localparam logic [1:0] S_SETUP2 = 2'd2;
    localparam logic [1:0] S_DRAW   = 2'd3;

    logic [1:0] state;

    // Shadow registers written by the CPU at any time.
    logic [23:0]   color_r;
    logic [CW-1:0] x0_r, y0_r, x1_r, y1_r;

    // Working copies owned by the line in progress.
    logic [23:0]          color_w;
    logic [CW-1:0]        xa, ya, xb, yb;
    logic [CW-1:0]        x, y;
    logic                 steep;
    logic                 ystep_neg;
    logic signed [CW+1:0] dx, dy, err;

    // Setup and step combinational helpers.
    logic signed [CW:0]   ddx, ddy, adx, ady;
    logic                 swap_ends;
    logic [CW-1:0]        sxa, sya, sxb, syb;
    logic signed [CW+1:0] dx_n, dy_n, e;
    logic                 draw;
    logic [CW-1:0]        plot_x, plot_y;
    logic                 unused_color_hi;

    // Only the low 24 color bits are stored; the top byte is ignored.
    assign unused_color_hi = ^line_color[31:24];

    // Shadow registers load on their strobe regardless of engine state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_r <= '0;
            x0_r    <= '0;
            y0_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
        end else begin
            if (line_color_valid) color_r <= line_color[23:0];
            if (line_x0_valid)    x0_r    <= line_point;
            if (line_y0_valid)    y0_r    <= line_point;
            if (line_x1_valid)    x1_r    <= line_point;
            if (line_y1_valid)    y1_r    <= line_point;
        end
    end

    // Setup arithmetic: steepness test on the raw endpoints, then ordering along the major axis.
    always_comb begin
        ddx       = $signed({1'b0, xb}) - $signed({1'b0, xa});
        ddy       = $signed({1'b0, yb}) - $signed({1'b0, ya});
        adx       = (ddx < 0) ? -ddx : ddx;
        ady       = (ddy < 0) ? -ddy : ddy;
        swap_ends = (xa > xb);
        sxa       = swap_ends ? xb : xa;
        sya       = swap_ends ? yb : ya;
        sxb       = swap_ends ? xa : xb;
        syb       = swap_ends ? ya : yb;
        dx_n      = $signed({2'b00, sxb}) - $signed({2'b00, sxa});
        dy_n      = $signed({2'b00, syb}) - $signed({2'b00, sya});
        e         = err - dy;
    end

    // Line sequencer: capture on trigger, two setup cycles, then step one pixel per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            color_w   <= '0;
            xa        <= '0;
            ya        <= '0;
            xb        <= '0;
            yb        <= '0;
            x         <= '0;
            y         <= '0;
            steep     <= 1'b0;
            ystep_neg <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Copies are taken here so a strobe in the trigger cycle cannot leak into this line.
                    if (line_trigger) begin
                        xa      <= x0_r;
                        ya      <= y0_r;
                        xb      <= x1_r;
                        yb      <= y1_r;
                        color_w <= color_r;
                        state   <= S_SETUP1;
                    end
                end
                S_SETUP1: begin
                    // A tie in span is drawn as a shallow line.
                    steep <= (ady > adx);
                    if (ady > adx) begin
                        xa <= ya;
                        ya <= xa;
                        xb <= yb;
                        yb <= xb;
                    end
                    state <= S_SETUP2;
                end
                S_SETUP2: begin
                    x         <= sxa;
                    y         <= sya;
                    xb        <= sxb;
                    dx        <= dx_n;
                    dy        <= (dy_n < 0) ? -dy_n : dy_n;
                    ystep_neg <= !(sya < syb);
                    err       <= dx_n >>> 1;
                    state     <= S_DRAW;
                end
                default: begin
                    if (px.px_ready) begin
                        if (x == xb) begin
                            state <= S_IDLE;
                        end else begin
                            x <= x + ONE;
                            if (e < 0) begin
                                y   <= ystep_neg ? (y - ONE) : (y + ONE);
                                err <= e + dx;
                            end else begin
                                err <= e;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Pixel outputs come straight from state so reset drops px_valid without waiting for a clock.
    always_comb begin
        draw        = (state == S_DRAW);
        plot_x      = steep ? y : x;
        plot_y      = steep ? x : y;
        line_ready  = (state == S_IDLE);
        px.px_valid = draw;
        px.px_we    = draw ? 4'hF : 4'h0;
        px.px_data  = draw ? {8'h00, color_w} : 32'h0;
        px.px_addr  = draw ? (FB_BASE | {{(32-2*CW-2){1'b0}}, plot_y, plot_x, 2'b00}) : 32'h0;
    end
endmodule

// File: tb/tb_line_engine.sv
// Testbench for line_engine: directed table, corner sequences and random lines against a closed-form model.
// Latency and busy time are measured against the trigger cycle.
// Backpressure is driven both as scripted stalls and as random px_ready.
module tb_line_engine;
    localparam logic [31:0] FB = 32'h1080_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] line_color;
    logic [9:0]  line_point;
    logic        line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid;
    logic        line_trigger;
    logic        line_ready;

    line_engine_if bus();

    line_engine #(.FB_BASE(FB), .COORD_W(10)) dut (
        .clk              (clk),
        .rst              (rst),
        .line_color       (line_color),
        .line_point       (line_point),
        .line_color_valid (line_color_valid),
        .line_x0_valid    (line_x0_valid),
        .line_y0_valid    (line_y0_valid),
        .line_x1_valid    (line_x1_valid),
        .line_y1_valid    (line_y1_valid),
        .line_trigger     (line_trigger),
        .line_ready       (line_ready),
        .px               (bus.master)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_d;
    logic [31:0] cap_a[$];
    logic [31:0] cap_d[$];
    int          we_bad;
    bit          rand_rdy = 1'b0;

    typedef struct {
        int           x0, y0, x1, y1;
        logic [31:0]  color;
        logic [31:0]  data;
        int           n;
        logic [127:0] addrs;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic logic [127:0] addrs4(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Closed-form Bresenham: the minor-axis offset after i steps is ceil((i*dy - dx/2) / dx), floored at 0.
    function automatic void build_exp(input int x0, y0, x1, y1);
        int ax, ay, bx, by, t, dx, dy, st, h, n, px, py;
        bit steep;
        exp_q.delete();
        steep = iabs(y1 - y0) > iabs(x1 - x0);
        ax = x0; ay = y0; bx = x1; by = y1;
        if (steep) begin
            t = ax; ax = ay; ay = t;
            t = bx; bx = by; by = t;
        end
        if (ax > bx) begin
            t = ax; ax = bx; bx = t;
            t = ay; ay = by; by = t;
        end
        dx = bx - ax;
        dy = iabs(by - ay);
        st = (ay < by) ? 1 : -1;
        h  = dx / 2;
        for (int i = 0; i <= dx; i++) begin
            n  = (dx == 0) ? 0 : (i * dy - h + dx - 1) / dx;
            px = ax + i;
            py = ay + st * n;
            if (steep) begin
                t = px; px = py; py = t;
            end
            exp_q.push_back(FB | (32'(py) << 12) | (32'(px) << 2));
        end
    endfunction

    // Record every accepted pixel and flag any byte-enable that disagrees with px_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.px_valid) begin
                if (bus.px_we !== 4'hF) we_bad++;
                if (bus.px_ready) begin
                    cap_a.push_back(bus.px_addr);
                    cap_d.push_back(bus.px_data);
                end
            end else if (bus.px_we !== 4'h0) begin
                we_bad++;
            end
        end
    end

    // Random px_ready, enabled only during the random-line phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.px_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes;
        line_color_valid = 0; line_x0_valid = 0; line_y0_valid = 0;
        line_x1_valid = 0; line_y1_valid = 0; line_trigger = 0;
    endtask

    task automatic load_line(input int x0, y0, x1, y1, input logic [31:0] c);
        line_color = c;            line_color_valid = 1; tick; clear_strobes();
        line_point = 10'(x0);      line_x0_valid = 1;    tick; clear_strobes();
        line_point = 10'(y0);      line_y0_valid = 1;    tick; clear_strobes();
        line_point = 10'(x1);      line_x1_valid = 1;    tick; clear_strobes();
        line_point = 10'(y1);      line_y1_valid = 1;    tick; clear_strobes();
    endtask

    task automatic prep(input int x0, y0, x1, y1, input logic [31:0] c);
        cap_a.delete();
        cap_d.delete();
        we_bad = 0;
        build_exp(x0, y0, x1, y1);
        exp_d = {8'h00, c[23:0]};
    endtask

    task automatic pulse_trigger;
        line_trigger = 1;
        tick;
        line_trigger = 0;
    endtask

    task automatic start_line(input int x0, y0, x1, y1, input logic [31:0] c);
        load_line(x0, y0, x1, y1, c);
        prep(x0, y0, x1, y1, c);
        pulse_trigger();
    endtask

    // Wait for line_ready (bounded), optionally check latency/busy time, then compare the captured stream.
    task automatic finish_line(input string nm, input bit timed);
        int idx = 0;
        int first = -1;
        int nbad = 0;
        int dbad = 0;
        bit done = 0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(negedge clk);
            if (line_ready) done = 1;
            else begin
                if (bus.px_valid && first < 0) first = idx;
                idx++;
            end
        end
        chk({nm, " done"}, 32'(done), 32'd1);
        if (timed) begin
            chk({nm, " first_valid_cycle"}, first, 2);
            chk({nm, " busy_cycles"}, idx, 2 + exp_q.size());
        end
        chk({nm, " count"}, cap_a.size(), exp_q.size());
        for (int i = 0; i < cap_a.size() && i < exp_q.size(); i++) begin
            if (cap_a[i] !== exp_q[i]) begin
                if (nbad == 0) $display("  %s first addr diff at %0d: got %h want %h", nm, i, cap_a[i], exp_q[i]);
                nbad++;
            end
            if (cap_d[i] !== exp_d) dbad++;
        end
        chk({nm, " addr_diffs"}, nbad, 0);
        chk({nm, " data_diffs"}, dbad, 0);
        chk({nm, " we_errors"}, we_bad, 0);
    endtask

    // Hold px_ready low for 5 cycles and require the presented pixel to stay put.
    task automatic hold_check(input string nm, input int pix);
        logic [31:0] ra, rd;
        int bad = 0;
        ra = bus.px_addr;
        rd = bus.px_data;
        chk({nm, " held_addr"}, ra, exp_q[pix]);
        repeat (5) begin
            @(negedge clk);
            if (!bus.px_valid || bus.px_addr !== ra || bus.px_data !== rd) bad++;
        end
        chk({nm, " stall_changes"}, bad, 0);
    endtask

    initial begin
        rst = 1;
        line_color = 0;
        line_point = 0;
        clear_strobes();
        bus.px_ready = 1;
        we_bad = 0;

        #12;
        chk("reset line_ready", 32'(line_ready), 32'd1);
        chk("reset px_valid", 32'(bus.px_valid), 32'd0);
        chk("reset px_we", 32'(bus.px_we), 32'd0);
        chk("reset px_addr", bus.px_addr, 32'd0);
        chk("reset px_data", bus.px_data, 32'd0);
        @(posedge clk);
        #1 rst = 0;
        tick;

        tbl[0] = '{0, 0, 3, 0, 32'h00FF8040, 32'h00FF8040, 4,
                   addrs4(32'h1080_0000, 32'h1080_0004, 32'h1080_0008, 32'h1080_000C)};
        tbl[1] = '{5, 0, 6, 3, 32'h1234_5678, 32'h0034_5678, 4,
                   addrs4(32'h1080_0014, 32'h1080_1014, 32'h1080_2018, 32'h1080_3018)};
        tbl[2] = '{3, 3, 0, 0, 32'hAABB_CCDD, 32'h00BB_CCDD, 4,
                   addrs4(32'h1080_0000, 32'h1080_1004, 32'h1080_2008, 32'h1080_300C)};
        tbl[3] = '{7, 9, 7, 9, 32'h0000_0001, 32'h0000_0001, 1,
                   addrs4(32'h1080_901C, 32'h0, 32'h0, 32'h0)};
        tbl[4] = '{0, 3, 3, 0, 32'h00AB_CDEF, 32'h00AB_CDEF, 4,
                   addrs4(32'h1080_3000, 32'h1080_2004, 32'h1080_1008, 32'h1080_000C)};
        tbl[5] = '{1023, 1023, 1023, 1023, 32'hFFFF_FFFF, 32'h00FF_FFFF, 1,
                   addrs4(32'h10BF_FFFC, 32'h0, 32'h0, 32'h0)};

        for (int t = 0; t < 6; t++) begin
            string nm;
            nm = $sformatf("vec%0d", t);
            start_line(tbl[t].x0, tbl[t].y0, tbl[t].x1, tbl[t].y1, tbl[t].color);
            finish_line(nm, 1);
            for (int i = 0; i < tbl[t].n; i++) begin
                chk($sformatf("%s addr%0d", nm, i),
                    (i < cap_a.size()) ? cap_a[i] : 32'hDEAD_DEAD, tbl[t].addrs[i*32 +: 32]);
            end
            chk({nm, " first_data"}, (cap_d.size() > 0) ? cap_d[0] : 32'hDEAD_DEAD, tbl[t].data);
        end

        // Strobe in the trigger cycle: the line uses the old x1, the next line the new one.
        load_line(0, 0, 3, 0, 32'h0000_00AA);
        prep(0, 0, 3, 0, 32'h0000_00AA);
        line_point = 10'd1;
        line_x1_valid = 1;
        line_trigger = 1;
        tick;
        clear_strobes();
        finish_line("pre_update", 1);
        prep(0, 0, 1, 0, 32'h0000_00AA);
        pulse_trigger();
        finish_line("post_update", 1);

        // All four point strobes in one cycle share line_point.
        line_point = 10'd5;
        line_x0_valid = 1; line_y0_valid = 1; line_x1_valid = 1; line_y1_valid = 1;
        tick;
        clear_strobes();
        prep(5, 5, 5, 5, 32'h0000_00AA);
        pulse_trigger();
        finish_line("multi_strobe", 1);
        chk("multi_strobe addr", (cap_a.size() > 0) ? cap_a[0] : 32'hDEAD_DEAD, 32'h1080_5014);

        // Scripted stalls: on the first pixel, then again after exactly one accept.
        bus.px_ready = 0;
        start_line(0, 0, 7, 2, 32'h0055_AA55);
        for (int k = 0; k < 20 && !bus.px_valid; k++) @(negedge clk);
        chk("bp valid_seen", 32'(bus.px_valid), 32'd1);
        hold_check("bp stall1", 0);
        @(posedge clk); #1 bus.px_ready = 1;
        @(posedge clk); #1 bus.px_ready = 0;
        @(negedge clk);
        hold_check("bp stall2", 1);
        @(posedge clk); #1 bus.px_ready = 1;
        finish_line("bp", 0);

        // Trigger and x1 strobe while busy: active line untouched, new x1 used by the next trigger.
        start_line(0, 0, 9, 3, 32'h0001_0203);
        repeat (4) tick;
        line_trigger = 1;
        line_point = 10'd2;
        line_x1_valid = 1;
        tick;
        clear_strobes();
        finish_line("busy", 0);
        repeat (4) tick;
        chk("busy no_queued_line", cap_a.size(), 10);
        chk("busy idle_after", 32'(line_ready), 32'd1);
        prep(0, 0, 2, 3, 32'h0001_0203);
        pulse_trigger();
        finish_line("after_busy", 1);

        // Random lines with random backpressure.
        rand_rdy = 1;
        for (int r = 0; r < 25; r++) begin
            int x0, y0, x1, y1, sx, sy;
            sx = (r % 2 == 0) ? 60 : 20;
            sy = (r % 2 == 0) ? 20 : 60;
            x0 = int'($urandom_range(0, 1023));
            y0 = int'($urandom_range(0, 1023));
            x1 = clampc(x0 + int'($urandom_range(0, 2 * sx)) - sx);
            y1 = clampc(y0 + int'($urandom_range(0, 2 * sy)) - sy);
            start_line(x0, y0, x1, y1, $urandom);
            finish_line($sformatf("rand%0d", r), 0);
        end
        rand_rdy = 0;
        tick;
        bus.px_ready = 1;

        // Reset mid-line: outputs drop at once and the shadows come back cleared.
        start_line(2, 2, 40, 20, 32'h00C0_FFEE);
        repeat (8) tick;
        #2 rst = 1;
        #1;
        chk("midreset px_valid", 32'(bus.px_valid), 32'd0);
        chk("midreset line_ready", 32'(line_ready), 32'd1);
        chk("midreset px_we", 32'(bus.px_we), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        tick;
        prep(0, 0, 0, 0, 32'h0);
        pulse_trigger();
        finish_line("after_reset", 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/line_engine.md
Name: line_engine

Overview:
- Hardware Bresenham line rasterizer between the Riscv150 CPU and the Memory150 frame-buffer write path.
- The CPU loads color and endpoint registers through per-field valid strobes, then pulses a trigger.
- The engine emits one frame-buffer pixel write per handshake until the line is complete.
- Its ready output is the line_ready status the CPU polls and that drives a GPIO LED.

Parameters:
- FB_BASE, 32'h1080_0000, frame-buffer byte base address; bits [21:0] must be zero.
- COORD_W, 10, width of each x/y coordinate.

Ports:
- clk  in  1  CPU clock (cpu_clk_g domain).
- rst  in  1  asynchronous, active-high reset.
- line_color  in  32  pixel color; only bits [23:0] are used.
- line_point  in  10  coordinate value written by the *_valid strobes.
- line_color_valid  in  1  latch line_color into color_r.
- line_x0_valid  in  1  latch line_point into x0_r.
- line_y0_valid  in  1  latch line_point into y0_r.
- line_x1_valid  in  1  latch line_point into x1_r.
- line_y1_valid  in  1  latch line_point into y1_r.
- line_trigger  in  1  start drawing; accepted only when line_ready=1.
- line_ready  out  1  high in IDLE only.
- px_addr  out  32  pixel byte address.
- px_data  out  32  {8'h00, color[23:0]}.
- px_we  out  4  byte-enable mask; 4'hF whenever px_valid=1, else 4'h0.
- px_valid  out  1  pixel write request.
- px_ready  in  1  downstream accepts the write when px_valid and px_ready are both high on a clk edge.

Behaviour:
- Reset (async assert, sync deassert assumed from top):
  - State IDLE.
  - line_ready=1, px_valid=0, px_we=0, px_addr=0, px_data=0.
  - All shadow and working registers cleared to 0.
- Shadow registers:
  - color_r, x0_r, y0_r, x1_r, y1_r update on any cycle their strobe is high, including while busy.
  - The current line is unaffected because the engine works on copies taken at trigger.
  - Multiple strobes in one cycle all load the same line_point.
- Trigger rules:
  - Trigger in IDLE starts a line; trigger when not IDLE is ignored, not queued.
  - Strobe and trigger in the same cycle: the trigger captures the pre-update shadow values.
- State SETUP1 (1 cycle):
  - Copy shadows to working registers.
  - steep = |y1-y0| > |x1-x0|, computed in 11-bit signed arithmetic.
  - If steep, swap x/y of each endpoint.
- State SETUP2 (1 cycle):
  - If xa > xb, swap the endpoints.
  - dx = xb-xa (>=0).
  - dy = |yb-ya|.
  - ystep = +1 if ya < yb, else -1.
  - err = dx>>1 (12-bit signed).
  - x = xa, y = ya.
- State DRAW:
  - px_valid=1; the first pixel is valid in the 3rd cycle after the trigger cycle.
  - Plotted point = steep ? (y,x) : (x,y).
  - px_addr = FB_BASE | {py, px, 2'b00}: y at bits [21:12], x at bits [11:2].
  - On handshake:
    - If x == xb, go to IDLE; px_valid drops and line_ready rises the next cycle.
    - Else x <= x+1 and e = err-dy.
    - If e < 0: y <= y+ystep and err <= e+dx; else err <= e.
  - px_addr, px_data and px_we hold stable while px_valid=1 and px_ready=0.
  - A new pixel can be presented every cycle with no bubbles while px_ready=1.
- Pixel count: exactly max(|dx|,|dy|)+1, in increasing major-axis order.
- No clipping: coordinates are written verbatim.
- Degenerate line (x0=x1, y0=y1) emits exactly one pixel.
- Tie |dx|==|dy| is treated as not steep.
- Reset mid-line: immediate return to IDLE; px_valid drops asynchronously; partial lines are not resumed.

Test Plan:
- Horizontal line: load color=32'h00FF8040, (0,0)-(3,0), trigger, px_ready=1.
  - Exactly 4 writes, px_addr 1080_0000, 1080_0004, 1080_0008, 1080_000C, px_data=32'h00FF8040.
  - First px_valid 3 cycles after trigger; line_ready low 2+4 cycles.
- Steep line: (5,0)-(6,3).
  - Pixels (5,0),(5,1),(6,2),(6,3) in that order.
  - Addresses 1080_0014, 1080_1014, 1080_2018, 1080_3018.
- Reversed diagonal: (3,3)-(0,0).
  - Pixels (0,0),(1,1),(2,2),(3,3) in that order, ascending x.
- Single point: (7,9)-(7,9).
  - Exactly one write at 1080_901C.
- Backpressure: hold px_ready=0 for 5 cycles mid-line.
  - px_valid=1 and px_addr/px_data unchanged throughout; no pixel skipped or duplicated.
- Busy interactions:
  - Trigger while busy is ignored; the pixel count of the active line is unchanged.
  - New x1_valid while busy does not alter the active line and is used by the next trigger.
  - Assert rst mid-line: px_valid=0 and line_ready=1 immediately; all shadows read 0.
